// File: rtl/sram_rmw_responder_if.sv
// Request/response bus between the RMW counter controller and its SRAM.
//   master : controller side, issues write bursts and read requests
//   slave  : memory side, returns read data and advisory full flags
// Signals:
//   dout / dout_addr / dout_burst_ready : write data, address, strobe
//   din_addr / din_ready                : read address, strobe
//   din / din_valid                     : read data and per-chip valid
//   sram_write_full / sram_read_full    : request FIFOs almost full
interface sram_rmw_responder_if #(
    parameter int MEM_WIDTH      = 36,
    parameter int NUM_MEM_INPUTS = 6,
    parameter int NUM_MEM_CHIPS  = 3,
    parameter int MEM_ADDR_WIDTH = 19
);
    localparam int DATA_W = MEM_WIDTH * NUM_MEM_INPUTS;

    logic [DATA_W-1:0]         dout;
    logic [MEM_ADDR_WIDTH-1:0] dout_addr;
    logic                      dout_burst_ready;
    logic [MEM_ADDR_WIDTH-1:0] din_addr;
    logic                      din_ready;
    logic [DATA_W-1:0]         din;
    logic [NUM_MEM_CHIPS-1:0]  din_valid;
    logic                      sram_write_full;
    logic                      sram_read_full;

    modport master (
        output dout, dout_addr, dout_burst_ready, din_addr, din_ready,
        input  din, din_valid, sram_write_full, sram_read_full
    );

    modport slave (
        input  dout, dout_addr, dout_burst_ready, din_addr, din_ready,
        output din, din_valid, sram_write_full, sram_read_full
    );
endinterface

// File: rtl/sram_rmw_responder.sv
// Memory-side responder for the RMW counter controller's SRAM interface.
// Write and read requests are queued in two small FIFOs, drained one entry
// per cycle into / out of an on-chip array, and read data is returned through
// a fixed-latency shift pipe. Stands in for the QDR PHY in simulation/builds.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   cal_done    : calibration complete, sticky until reset
//   drop_count  : saturating count of discarded requests
//   bus         : slave side of sram_rmw_responder_if (requests, read data,
//                 full flags)
module sram_rmw_responder #(
    parameter int MEM_WIDTH      = 36,
    parameter int NUM_MEM_INPUTS = 6,
    parameter int NUM_MEM_CHIPS  = 3,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int ARRAY_AW       = 11,
    parameter int FIFO_AW        = 3,
    parameter int READ_LATENCY   = 4,
    parameter int CAL_CYCLES     = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cal_done,
    output logic [15:0] drop_count,
    sram_rmw_responder_if.slave bus
);
    localparam int DATA_W  = MEM_WIDTH * NUM_MEM_INPUTS;
    localparam int ENTRY_W = ARRAY_AW + DATA_W;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_THR  = (FIFO_AW+1)'(DEPTH - 2);
    localparam logic [15:0]      CAL_LAST = 16'(CAL_CYCLES - 1);

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Upper address bits are deliberately ignored (array aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.dout_addr[MEM_ADDR_WIDTH-1:ARRAY_AW],
                                bus.din_addr[MEM_ADDR_WIDTH-1:ARRAY_AW]};

    // ---------------- calibration ----------------
    logic [15:0] cal_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cal_cnt  <= '0;
            cal_done <= 1'b0;
        end else if (!cal_done) begin
            if (cal_cnt == CAL_LAST) cal_done <= 1'b1;
            cal_cnt <= cal_cnt + 16'd1;
        end
    end

    // ---------------- request FIFOs ----------------
    logic [ENTRY_W-1:0] wr_fifo [DEPTH];
    logic [ENTRY_W-1:0] rd_fifo [DEPTH];
    logic [FIFO_AW:0]   wr_wptr, wr_rptr, rd_wptr, rd_rptr;
    logic [FIFO_AW:0]   wr_count, rd_count;
    logic               wr_accept, rd_accept, wr_drop, rd_drop;
    logic               wr_pop_en, rd_pop_en;

    assign wr_count = wr_wptr - wr_rptr;
    assign rd_count = rd_wptr - rd_rptr;

    // Accept decision uses the count before any same-cycle pop.
    assign wr_accept = bus.dout_burst_ready && cal_done && (wr_count != CNT_FULL);
    assign rd_accept = bus.din_ready        && cal_done && (rd_count != CNT_FULL);
    assign wr_drop   = bus.dout_burst_ready && !wr_accept;
    assign rd_drop   = bus.din_ready        && !rd_accept;

    // Pops look only at registered pointers, so a push to an empty FIFO
    // is popped no earlier than the following cycle.
    assign wr_pop_en = (wr_count != '0);
    assign rd_pop_en = (rd_count != '0);

    assign bus.sram_write_full = (wr_count >= CNT_THR);
    assign bus.sram_read_full  = (rd_count >= CNT_THR);

    always_ff @(posedge clk) begin
        if (wr_accept) wr_fifo[wr_wptr[FIFO_AW-1:0]] <= {bus.dout_addr[ARRAY_AW-1:0], bus.dout};
        if (rd_accept) rd_fifo[rd_wptr[FIFO_AW-1:0]] <= {bus.din_addr[ARRAY_AW-1:0], {DATA_W{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_wptr    <= '0;
            wr_rptr    <= '0;
            rd_wptr    <= '0;
            rd_rptr    <= '0;
            drop_count <= '0;
        end else begin
            if (wr_accept) wr_wptr <= wr_wptr + 1'b1;
            if (rd_accept) rd_wptr <= rd_wptr + 1'b1;
            if (wr_pop_en) wr_rptr <= wr_rptr + 1'b1;
            if (rd_pop_en) rd_rptr <= rd_rptr + 1'b1;
            drop_count <= sat_add16(drop_count, {1'b0, wr_drop} + {1'b0, rd_drop});
        end
    end

    // ---------------- array ----------------
    logic [ENTRY_W-1:0] wr_head, rd_head;
    logic [ARRAY_AW-1:0] wr_head_addr, rd_head_addr;
    logic [DATA_W-1:0]  wr_head_data;
    logic [DATA_W-1:0]  mem [2**ARRAY_AW];

    assign wr_head      = wr_fifo[wr_rptr[FIFO_AW-1:0]];
    assign rd_head      = rd_fifo[rd_rptr[FIFO_AW-1:0]];
    assign wr_head_addr = wr_head[ENTRY_W-1 -: ARRAY_AW];
    assign wr_head_data = wr_head[DATA_W-1:0];
    assign rd_head_addr = rd_head[ENTRY_W-1 -: ARRAY_AW];

    logic unused_rd_head_data;
    assign unused_rd_head_data = ^rd_head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (wr_pop_en) mem[wr_head_addr] <= wr_head_data;
    end

    // ---------------- read pipe ----------------
    // Stage 0 captures the array read issued on the pop cycle; because the
    // write above is non-blocking, a same-cycle write to the same address
    // is not visible here (read-first).
    logic              rd_vld_p [READ_LATENCY-1];
    logic [DATA_W-1:0] rd_dat_p [READ_LATENCY-1];

    always_ff @(posedge clk) begin
        rd_dat_p[0] <= mem[rd_head_addr];
        for (int i = 1; i < READ_LATENCY-1; i++) rd_dat_p[i] <= rd_dat_p[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY-1; i++) rd_vld_p[i] <= 1'b0;
        end else begin
            rd_vld_p[0] <= rd_pop_en;
            for (int i = 1; i < READ_LATENCY-1; i++) rd_vld_p[i] <= rd_vld_p[i-1];
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.din       <= '0;
            bus.din_valid <= '0;
        end else begin
            bus.din       <= rd_vld_p[READ_LATENCY-2] ? rd_dat_p[READ_LATENCY-2] : '0;
            bus.din_valid <= {NUM_MEM_CHIPS{rd_vld_p[READ_LATENCY-2]}};
        end
    end
endmodule

// File: tb/tb_sram_rmw_responder.sv
module tb_sram_rmw_responder;
    localparam int DW = 216;

    logic        clk = 1'b0;
    logic        reset;
    logic        cal_done;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    sram_rmw_responder_if bus ();

    sram_rmw_responder dut (
        .clk        (clk),
        .reset      (reset),
        .cal_done   (cal_done),
        .drop_count (drop_count),
        .bus        (bus.slave)
    );

    int cmp_cnt = 0;
    int mis_cnt = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int last_valid_cyc = -1;
    logic [DW-1:0] exp_q [$];
    logic [15:0]   exp_drop;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample #1 after the edge, and score any read data.
    task automatic tick();
        logic [DW-1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.din_valid !== 3'b000) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            chk("din_valid_bits", DW'(bus.din_valid), DW'(3'b111));
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", DW'(bus.din_valid), '0);
            end else begin
                e = exp_q.pop_front();
                chk("din_data", bus.din, e);
            end
        end else begin
            chk("din_idle_zero", bus.din, '0);
        end
    endtask

    task automatic wr_req(input logic [18:0] a, input logic [DW-1:0] d);
        bus.dout_addr        = a;
        bus.dout             = d;
        bus.dout_burst_ready = 1'b1;
        tick();
        bus.dout_burst_ready = 1'b0;
    endtask

    task automatic rd_req(input logic [18:0] a, input logic [DW-1:0] e, output int strobe_cyc);
        bus.din_addr  = a;
        bus.din_ready = 1'b1;
        exp_q.push_back(e);
        strobe_cyc = cyc;
        tick();
        bus.din_ready = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {8'(i), {52{4'h5}}} ^ DW'(i * 32'h0001_0203);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, vc0, cal0;
        logic [DW-1:0] dabc;
        dabc = {12'hABC, {51{4'hC}}};

        bus.dout = '0; bus.dout_addr = '0; bus.dout_burst_ready = 1'b0;
        bus.din_addr = '0; bus.din_ready = 1'b0;
        reset = 1'b1;
        repeat (4) tick();

        // Reset state
        chk("rst_cal_done",   DW'(cal_done), '0);
        chk("rst_drop_count", DW'(drop_count), '0);
        chk("rst_din_valid",  DW'(bus.din_valid), '0);
        chk("rst_din",        bus.din, '0);
        chk("rst_write_full", DW'(bus.sram_write_full), '0);
        chk("rst_read_full",  DW'(bus.sram_read_full), '0);

        // Test 1: calibration window and pre-cal drops
        reset = 1'b0;
        cal0 = cyc;
        repeat (10) tick();
        bus.dout_addr = 19'd3; bus.din_addr = 19'd3;
        bus.dout_burst_ready = 1'b1; bus.din_ready = 1'b1;
        tick();
        bus.dout_burst_ready = 1'b0; bus.din_ready = 1'b0;
        exp_drop = 16'd2;
        chk("precal_drop_count", DW'(drop_count), DW'(exp_drop));
        while (cyc - cal0 < 63) tick();
        chk("cal_done_at_63", DW'(cal_done), '0);
        tick();
        chk("cal_done_at_64", DW'(cal_done), DW'(1'b1));
        chk("no_valid_precal", DW'(valid_cnt), '0);

        // Test 2: write then read, latency READ_LATENCY+1 from strobe
        wr_req(19'd5, dabc);
        repeat (2) tick();
        vc0 = valid_cnt;
        rd_req(19'd5, dabc, s);
        repeat (6) tick();
        chk("rd_latency", DW'(last_valid_cyc - s), DW'(5));
        chk("rd_one_valid", DW'(valid_cnt - vc0), DW'(1));

        // Test 3: read-first on same-cycle pops, aliasing of upper bits
        wr_req(19'h007FF, DW'(8'h55));
        repeat (3) tick();
        bus.dout_addr = 19'h007FF; bus.dout = DW'(1); bus.dout_burst_ready = 1'b1;
        bus.din_addr = 19'h407FF;  bus.din_ready = 1'b1;
        exp_q.push_back(DW'(8'h55));
        tick();
        bus.dout_burst_ready = 1'b0;
        bus.din_addr = 19'h007FF;
        exp_q.push_back(DW'(1));
        tick();
        bus.din_ready = 1'b0;
        repeat (8) tick();
        chk("rf_queue_drained", DW'(exp_q.size()), '0);

        // Test 4: 12 back-to-back reads in order
        for (int i = 0; i < 12; i++) wr_req(19'(16 + i), pat(i));
        repeat (3) tick();
        vc0 = valid_cnt;
        s = cyc;
        bus.din_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.din_addr = 19'(16 + i);
            exp_q.push_back(pat(i));
            tick();
        end
        bus.din_ready = 1'b0;
        repeat (8) tick();
        chk("burst_valid_count", DW'(valid_cnt - vc0), DW'(12));
        chk("burst_last_valid",  DW'(last_valid_cyc - s), DW'(16));
        chk("burst_drop_count",  DW'(drop_count), DW'(exp_drop));

        // Test 5: write FIFO fills with its pop held off
        force dut.wr_pop_en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            wr_req(19'(40 + k - 1), pat(100 + k));
            chk("wfull_flag", DW'(bus.sram_write_full), DW'((k >= 6) ? 1'b1 : 1'b0));
        end
        exp_drop = exp_drop + 16'd2;
        chk("wfull_drop_count", DW'(drop_count), DW'(exp_drop));
        release dut.wr_pop_en;
        repeat (10) tick();
        chk("wfull_drained", DW'(bus.sram_write_full), '0);
        rd_req(19'd40, pat(101), s);
        rd_req(19'd47, pat(108), s);
        repeat (8) tick();

        // Test 6: reset with reads in flight
        rd_req(19'd16, pat(0), s);
        rd_req(19'd17, pat(1), s);
        rd_req(19'd18, pat(2), s);
        tick();
        reset = 1'b1;
        exp_q.delete();
        vc0 = valid_cnt;
        tick();
        chk("rst_kill_valid", DW'(bus.din_valid), '0);
        repeat (2) tick();
        reset = 1'b0;
        cal0 = cyc;
        chk("rst_drop_cleared", DW'(drop_count), '0);
        repeat (10) tick();
        chk("no_stale_valid", DW'(valid_cnt - vc0), '0);
        while (cyc - cal0 < 63) tick();
        chk("recal_at_63", DW'(cal_done), '0);
        tick();
        chk("recal_at_64", DW'(cal_done), DW'(1'b1));
        chk("final_queue_empty", DW'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end
endmodule
